priority_index_decoder: RTL and testbench

- Decoder end of the priority-encoder path: accepts an encoded index with valid from an encoder stage and drives the matching one-hot line.
- The one-hot output is registered and held for a programmable number of cycles, so downstream single-line consumers see a stable strobe.
- A valid/ready handshake on the input means an upstream encoder never loses a request while a strobe is in progress.

---
 rtl/priority_index_decoder_pkg.sv | 22 ++
 rtl/priority_index_decoder_hold_counter.sv | 31 +++
 rtl/priority_index_decoder.sv | 99 +++++++++
 tb/tb_priority_index_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/priority_index_decoder_pkg.sv
// Shared types and helpers for the index-to-one-hot decoder and its strobe stretcher.
package priority_index_decoder_pkg;

  localparam int DEC_N_DEFAULT    = 4;
  localparam int DEC_HOLD_DEFAULT = 3;
  localparam int DEC_MAX_N        = 64;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_t;

  // Mask is all-zero when the index does not name one of the n lines.
  function automatic logic [DEC_MAX_N-1:0] onehot_of(input int unsigned index,
                                                     input int unsigned n);
    logic [DEC_MAX_N-1:0] mask;
    mask = {{(DEC_MAX_N-1){1'b0}}, 1'b1} << index;
    if (index >= n) mask = '0;
    return mask;
  endfunction

endpackage

// File: rtl/priority_index_decoder_hold_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module hold_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (load)                 cnt_d = load_val;
    else if (dec && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/priority_index_decoder.sv
// Decodes an accepted index into a registered one-hot strobe held for HOLD_CYCLES cycles.
module priority_index_decoder
  import priority_index_decoder_pkg::*;
#(
  parameter int N           = DEC_N_DEFAULT,
  parameter int IDX_W       = 2,
  parameter int HOLD_CYCLES = DEC_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_index,
  output logic             in_ready,
  output logic [N-1:0]     out_onehot,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  dec_state_t              state_q, state_d;
  logic [N-1:0]            onehot_q, onehot_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic                    accept, in_range;
  logic [DEC_MAX_N-1:0]    mask_full;

  assign mask_full = onehot_of(32'(in_index), N);
  assign in_range  = |mask_full;
  assign in_ready  = en && (state_q == IDLE || (state_q == HOLD && cnt_zero));
  assign accept    = in_valid && in_ready;

  hold_counter #(.W(CNT_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      onehot_d = '0;
      busy_d   = 1'b0;
      cnt_clr  = 1'b1;
    end else if (accept && in_range) begin
      state_d  = HOLD;
      onehot_d = mask_full[N-1:0];
      busy_d   = 1'b1;
      cnt_load = 1'b1;
    end else begin
      // An out-of-range request is consumed but only flags err; a running strobe ends on time.
      err_d = accept;
      if (state_q == HOLD) begin
        if (cnt_zero) begin
          state_d  = IDLE;
          onehot_d = '0;
          busy_d   = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = busy_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_priority_index_decoder.sv
// Directed bench: an N=4 and an N=3 decoder checked every cycle against a remaining-cycles model.
module tb_priority_index_decoder;

  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a = 1'b0, v_a = 1'b0;
  logic [1:0] idx_a = 2'd0;
  logic       rdy_a, ov_a, busy_a, err_a;
  logic [3:0] oh_a;

  logic       en_b = 1'b0, v_b = 1'b0;
  logic [1:0] idx_b = 2'd0;
  logic       rdy_b, ov_b, busy_b, err_b;
  logic [2:0] oh_b;

  priority_index_decoder #(.N(4), .IDX_W(2), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .in_valid(v_a), .in_index(idx_a),
    .in_ready(rdy_a), .out_onehot(oh_a), .out_valid(ov_a), .busy(busy_a), .err(err_a)
  );

  priority_index_decoder #(.N(3), .IDX_W(2), .HOLD_CYCLES(HOLD)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .in_valid(v_b), .in_index(idx_b),
    .in_ready(rdy_b), .out_onehot(oh_b), .out_valid(ov_b), .busy(busy_b), .err(err_b)
  );

  logic       en_v[2], val_v[2], rdy_v[2], ov_v[2], busy_v[2], err_v[2];
  logic [1:0] idx_v[2];
  logic [3:0] oh_v[2];
  assign en_v[0] = en_a;  assign val_v[0] = v_a;  assign idx_v[0] = idx_a;
  assign en_v[1] = en_b;  assign val_v[1] = v_b;  assign idx_v[1] = idx_b;
  assign rdy_v[0] = rdy_a; assign ov_v[0] = ov_a; assign busy_v[0] = busy_a; assign err_v[0] = err_a;
  assign rdy_v[1] = rdy_b; assign ov_v[1] = ov_b; assign busy_v[1] = busy_b; assign err_v[1] = err_b;
  assign oh_v[0] = oh_a;
  assign oh_v[1] = {1'b0, oh_b};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rem = strobe cycles still to show (0 = idle); ready whenever rem <= 1.
  int         rem[2];
  int         line[2];
  logic       merr[2];
  int         n_lines[2];
  initial begin
    n_lines[0] = 4;
    n_lines[1] = 3;
  end

  always @(posedge clk or posedge rst) begin
    logic rdy, acc;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        rem[k]  <= 0;
        line[k] <= 0;
        merr[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy = en_v[k] && (rem[k] <= 1);
        acc = val_v[k] && rdy;
        if (acc) $display("accept dut%0d index %0d at %0t", k, idx_v[k], $time);
        if (!en_v[k]) begin
          rem[k]  <= 0;
          merr[k] <= 1'b0;
        end else if (acc && int'(idx_v[k]) < n_lines[k]) begin
          rem[k]  <= HOLD;
          line[k] <= int'(idx_v[k]);
          merr[k] <= 1'b0;
        end else begin
          rem[k]  <= (rem[k] > 0) ? rem[k] - 1 : 0;
          merr[k] <= acc;
        end
      end
    end
  end

  logic cmp_on = 1'b0;
  always @(negedge clk) begin
    logic [3:0] exp_oh;
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        exp_oh = (rem[k] > 0) ? 4'(1 << line[k]) : 4'd0;
        chk($sformatf("m%0d_onehot", k), 32'(oh_v[k]), 32'(exp_oh));
        chk($sformatf("m%0d_valid", k), 32'(ov_v[k]), 32'(rem[k] > 0));
        chk($sformatf("m%0d_busy", k), 32'(busy_v[k]), 32'(rem[k] > 0));
        chk($sformatf("m%0d_ready", k), 32'(rdy_v[k]), 32'(en_v[k] && rem[k] <= 1));
        chk($sformatf("m%0d_err", k), 32'(err_v[k]), 32'(merr[k]));
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge; return just after the compare edge.
  task automatic cyc(input logic e, input logic v, input logic [1:0] i,
                     input logic vb, input logic [1:0] ib);
    @(posedge clk);
    #1;
    en_a = e; v_a = v; idx_a = i;
    v_b = vb; idx_b = ib;
    @(negedge clk);
    #1;
  endtask

  logic [3:0] exp_single[4];
  logic       exp_single_rdy[4];

  initial begin
    exp_single[0] = 4'b0100; exp_single[1] = 4'b0100;
    exp_single[2] = 4'b0100; exp_single[3] = 4'b0000;
    exp_single_rdy[0] = 1'b0; exp_single_rdy[1] = 1'b0;
    exp_single_rdy[2] = 1'b1; exp_single_rdy[3] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
    cmp_on = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_onehot", 32'(oh_a), 32'h0);
    chk("reset_valid", 32'(ov_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    chk("reset_ready", 32'(rdy_a), 32'h1);

    // single strobe, index 2
    cyc(1, 1, 2'd2, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 2'd0, 0, 2'd0);
      chk($sformatf("single_oh%0d", i), 32'(oh_a), 32'(exp_single[i]));
      chk($sformatf("single_rdy%0d", i), 32'(rdy_a), 32'(exp_single_rdy[i]));
    end

    // back-to-back 3 then 0 with valid held
    cyc(1, 1, 2'd3, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2'd0, 0, 2'd0);
      chk($sformatf("b2b_first%0d", i), 32'(oh_a), 32'h8);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2'd0, 0, 2'd0);
      chk($sformatf("b2b_second%0d", i), 32'(oh_a), 32'h1);
    end
    cyc(1, 0, 2'd0, 0, 2'd0);
    chk("b2b_end", 32'(oh_a), 32'h0);

    // enable abort in the second hold cycle
    cyc(1, 1, 2'd1, 0, 2'd0);
    cyc(1, 0, 2'd0, 0, 2'd0);
    chk("abort_hold1", 32'(oh_a), 32'h2);
    cyc(0, 0, 2'd0, 0, 2'd0);
    chk("abort_rdy_low", 32'(rdy_a), 32'h0);
    cyc(0, 1, 2'd2, 0, 2'd0);
    chk("abort_cleared", 32'(oh_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    cyc(0, 0, 2'd0, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2'd0, 0, 2'd0);
      chk($sformatf("reenable_idle%0d", i), 32'(oh_a), 32'h0);
    end

    // invalid index on the 3-line decoder, then a valid one
    cyc(1, 0, 2'd0, 1, 2'd3);
    cyc(1, 0, 2'd0, 0, 2'd0);
    chk("inv_err", 32'(err_b), 32'h1);
    chk("inv_oh", 32'(oh_b), 32'h0);
    chk("inv_rdy", 32'(rdy_b), 32'h1);
    cyc(1, 0, 2'd0, 1, 2'd2);
    chk("inv_err_drop", 32'(err_b), 32'h0);
    cyc(1, 0, 2'd0, 0, 2'd0);
    chk("b_line2", 32'(oh_b), 32'h4);
    repeat (3) cyc(1, 0, 2'd0, 0, 2'd0);

    // asynchronous reset between edges while strobing index 1
    cyc(1, 1, 2'd1, 0, 2'd0);
    cyc(1, 0, 2'd0, 0, 2'd0);
    chk("areset_pre", 32'(oh_a), 32'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("areset_oh", 32'(oh_a), 32'h0);
    chk("areset_valid", 32'(ov_a), 32'h0);
    chk("areset_busy", 32'(busy_a), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; v_a = 1'b1; idx_a = 2'd0;
    @(negedge clk);
    #1;
    chk("post_reset_rdy", 32'(rdy_a), 32'h1);
    cyc(1, 0, 2'd0, 0, 2'd0);
    chk("post_reset_oh", 32'(oh_a), 32'h1);
    repeat (4) cyc(1, 0, 2'd0, 0, 2'd0);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
